spi_regfile_peripheral: RTL and testbench
=========================================

# spi_regfile_peripheral

Parametrised SPI target that drives a bank of `NUM_REGS` configuration registers, each `DATA_W` bits wide, from an external SPI controller. It generalises the fixed five-register, write-only peripheral: register count, data/address width, clock polarity and synchroniser depth are configurable. It adds a frame-error flag, per-register write strobes, and optional register readback on CIPO. It sits between the chip pins and the PWM/output-enable logic, in the `clk` domain.

## Interface

Parameters:
- `NUM_REGS`, 5: number of registers; legal addresses are 0..NUM_REGS-1.
- `DATA_W`, 8: register and data-field width.
- `ADDR_W`, 7: address-field width.
- `SYNC_STAGES`, 2: flops per pin synchroniser; minimum 2.
- `CPOL`, 0: SCLK idle level. CPHA is always 0: sample on the leading edge, shift on the trailing edge.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset. Asynchronous assert, active-low.
- `SCLK` in 1: SPI clock, asynchronous to `clk`.
- `COPI` in 1: controller-out data.
- `nCS` in 1: active-low chip select.
- `CIPO` out 1: controller-in data.
- `cipo_oe` out 1: CIPO pad output enable.
- `regs_flat` out NUM_REGS*DATA_W: register r occupies bits [r*DATA_W +: DATA_W].
- `wr_strobe` out NUM_REGS: one-cycle pulse on the bit of the register just written.
- `frame_err` out 1: one-cycle pulse when a frame is rejected.

## Operation

- Frame length FRAME_LEN = 1 + ADDR_W + DATA_W; the default is 16.
- Frame layout, MSB first:
  - R/W bit: 1 = write, 0 = read.
  - ADDR_W address bits.
  - DATA_W data bits.
- `SCLK`, `COPI` and `nCS` each pass through a SYNC_STAGES synchroniser. Edges are detected on the synchronised SCLK against its previous value.
  - Leading edge: rising if CPOL=0, falling if CPOL=1.
- FSM states:
  - IDLE: synchronised nCS high.
    - Synchronised nCS falls → ACTIVE. Clear the bit counter and the shift register.
  - ACTIVE: on each leading edge, shift synchronised COPI into the shift register and increment the bit counter.
    - The counter saturates at FRAME_LEN+1 and never wraps.
    - Synchronised nCS rises → COMMIT.
  - COMMIT (exactly one cycle) → IDLE.
    - Write with count == FRAME_LEN and address < NUM_REGS: load the data field into that register and pulse its `wr_strobe` bit.
    - Read with count == FRAME_LEN: no register change and no error.
    - Count ≠ FRAME_LEN, with count ≠ 0: pulse `frame_err`. No register change.
    - Address ≥ NUM_REGS on a full-length frame: pulse `frame_err`. No register change.
    - Count == 0, a select with no clocks: silent, no action.
- Registers change only in COMMIT. No partial frame ever alters `regs_flat`.
- Reset values:
  - All registers 0.
  - `wr_strobe` = 0, `frame_err` = 0.
  - `CIPO` = 0, `cipo_oe` = 0.
  - FSM in IDLE, counter and shift registers 0.
- Reset mid-frame: the frame is abandoned. After release, the FSM waits in IDLE for a fresh nCS falling edge. If nCS is already low at release, the rest of that frame is ignored until nCS goes high.

## Timing

- SCLK high and low phases must each be ≥ SYNC_STAGES+2 `clk` cycles.
- nCS must stay high ≥ SYNC_STAGES+3 `clk` cycles between frames.
- Write latency: the register update and `wr_strobe` occur in the COMMIT cycle, SYNC_STAGES+2 `clk` cycles after the nCS rising edge at the pin.
- Readback timing:
  - The output bit changes SYNC_STAGES+1 `clk` cycles after the pin-level trailing edge.
  - The controller samples on the next leading edge, which the phase minimum above makes safe.
- `wr_strobe` and `frame_err` are single-cycle pulses and never assert in the same cycle.

## Configuration

- `SPI_READBACK_EN` defined:
  - After the address field of a read frame (count == 1+ADDR_W), load the addressed register into an output shift register. Out-of-range addresses load 0.
  - Shift MSB first onto `CIPO`, one bit per synchronised trailing edge.
  - `cipo_oe` = 1 while in ACTIVE; `CIPO` = 0 outside the data phase.
- `SPI_READBACK_EN` undefined:
  - `CIPO` and `cipo_oe` are tied to 0 and no output shift register exists.
  - Read frames are still length-checked and otherwise ignored.

## Structure

- Package `spi_pkg`:
  - FSM state enum {IDLE, ACTIVE, COMMIT}.
  - R/W encoding constants (WR = 1, RD = 0).
  - A function computing FRAME_LEN from ADDR_W and DATA_W.
- Sub-module `spi_sync`: a parametrised SYNC_STAGES flop chain, instantiated once per pin with a configurable reset value. nCS resets to 1; the other pins reset to 0.

## Test plan

- Write 0xA5 to address 4, CPOL=0 → `regs_flat[39:32]` = 0xA5. `wr_strobe` = 5'b10000 for exactly one cycle. Other registers stay 0.
- Write 0x77 to address 5, NUM_REGS=5 → no register change, one `frame_err` pulse, `wr_strobe` stays 0.
- 12-bit frame, then a 17-bit frame, each writing address 1 → `frame_err` pulses once per frame and register 1 is unchanged.
- With `SPI_READBACK_EN`: write 0x3C to address 2, then read address 2.
  - `CIPO` carries 0,0,1,1,1,1,0,0 across the data phase.
  - `cipo_oe` is high only while nCS is low.
- Assert `rst_n` after 10 bits of a write to address 0 with data 0xFF, release, and send a clean write of 0x01 → the aborted frame is lost and register 0 = 0x01.
- CPOL=1, write 0x5A to address 3 → register 3 = 0x5A. Checks that leading-edge sampling uses SCLK falling edges.

Source files
------------

// File: rtl/spi_regfile_peripheral_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_peripheral_if.sv
// SPI pin bundle between an external controller (master) and the peripheral (slave).
interface spi_regfile_peripheral_if;
  logic SCLK;
  logic COPI;
  logic nCS;
  logic CIPO;
  logic cipo_oe;

  modport master (output SCLK, output COPI, output nCS, input CIPO, input cipo_oe);
  modport slave  (input SCLK, input COPI, input nCS, output CIPO, output cipo_oe);
endinterface

// File: rtl/spi_regfile_peripheral_sync.sv
// Flop-chain synchroniser for one asynchronous pin, with a selectable reset level.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {STAGES{RESET_VAL}};
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// SPI target (CPHA=0) writing a bank of configuration registers in the clk domain.
// Define SPI_READBACK_EN to enable register readback on CIPO during read frames.
module spi_regfile_peripheral
  import spi_pkg::*;
#(
  parameter int   NUM_REGS    = 5,
  parameter int   DATA_W      = 8,
  parameter int   ADDR_W      = 7,
  parameter int   SYNC_STAGES = 2,
  parameter logic CPOL        = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  spi_regfile_peripheral_if.slave      spi,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic [NUM_REGS-1:0]          wr_strobe,
  output logic                         frame_err
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);

  logic sclk_s, copi_s, ncs_s, flushed;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(spi.SCLK), .q_o(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d_i(spi.COPI), .q_o(copi_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(spi.nCS), .q_o(ncs_s));
  // Goes high once the pin chains hold real pin values rather than reset values.
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_flush (
    .clk(clk), .rst_n(rst_n), .d_i(1'b1), .q_o(flushed));

  state_e                           state_q, state_d;
  logic                             sclk_prev_q;
  logic                             armed_q;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]             shift_q, shift_d;
  logic [NUM_REGS-1:0]              strobe_q, strobe_d;
  logic                             err_q, err_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q;

  logic                             lead;
  logic                             frame_rw;
  logic [ADDR_W-1:0]                frame_addr;
  logic [DATA_W-1:0]                frame_data;
  logic                             addr_ok;

  assign lead = (CPOL == 1'b0) ? (sclk_s & ~sclk_prev_q) : (~sclk_s & sclk_prev_q);

  assign frame_rw   = shift_q[FRAME_LEN-1];
  assign frame_addr = shift_q[DATA_W +: ADDR_W];
  assign frame_data = shift_q[DATA_W-1:0];
  assign addr_ok    = ({1'b0, frame_addr} < (ADDR_W+1)'(NUM_REGS));

  // armed_q only sets after nCS is seen high post-reset, so a frame already in
  // progress at reset release is ignored until nCS returns high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      strobe_q    <= '0;
      err_q       <= 1'b0;
      regs_q      <= '0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_s;
      armed_q     <= armed_q | (flushed & ncs_s);
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      strobe_q    <= strobe_d;
      err_q       <= err_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (strobe_d[r]) begin
          regs_q[r] <= frame_data;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    strobe_d = '0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        shift_d = '0;
        if (armed_q && !ncs_s) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (ncs_s) begin
          state_d = COMMIT;
        end else if (lead) begin
          shift_d = {shift_q[FRAME_LEN-2:0], copi_s};
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (cnt_q == CNT_FULL) begin
          if (frame_rw == WR) begin
            if (addr_ok) begin
              for (int r = 0; r < NUM_REGS; r++) begin
                if (frame_addr == ADDR_W'(r)) begin
                  strobe_d[r] = 1'b1;
                end
              end
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (cnt_q != '0) begin
          err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign regs_flat = regs_q;
  assign wr_strobe = strobe_q;
  assign frame_err = err_q;

`ifdef SPI_READBACK_EN
  logic              trail;
  logic              rd_load;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] out_shift_q;
  logic              rd_phase_q;
  logic              cipo_q;

  assign trail   = (CPOL == 1'b0) ? (~sclk_s & sclk_prev_q) : (sclk_s & ~sclk_prev_q);
  // Load on the leading edge that completes the address field.
  assign rd_load = (state_q == ACTIVE) && !ncs_s && lead && (cnt_q == CNT_ADDR);
  assign rd_addr = shift_d[ADDR_W-1:0];

  always_comb begin
    rd_val = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (rd_addr == ADDR_W'(r)) begin
        rd_val = regs_q[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_shift_q <= '0;
      rd_phase_q  <= 1'b0;
      cipo_q      <= 1'b0;
    end else if (state_q != ACTIVE) begin
      out_shift_q <= '0;
      rd_phase_q  <= 1'b0;
      cipo_q      <= 1'b0;
    end else if (rd_load) begin
      out_shift_q <= rd_val;
      rd_phase_q  <= (shift_d[ADDR_W] == RD);
    end else if (trail) begin
      if (rd_phase_q && (cnt_q < CNT_FULL)) begin
        cipo_q      <= out_shift_q[DATA_W-1];
        out_shift_q <= {out_shift_q[DATA_W-2:0], 1'b0};
      end else begin
        cipo_q <= 1'b0;
      end
    end
  end

  assign spi.CIPO    = cipo_q;
  assign spi.cipo_oe = (state_q == ACTIVE);
`else
  assign spi.CIPO    = 1'b0;
  assign spi.cipo_oe = 1'b0;
`endif

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Bench: directed table plus randomized frames on a CPOL=0 and a CPOL=1 instance,
// checked against a frame-level register model.
module tb_spi_regfile_peripheral;

  localparam int H = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_regfile_peripheral_if if0();
  spi_regfile_peripheral_if if1();

  logic [39:0] regs0, regs1;
  logic [4:0]  stb0, stb1;
  logic        err0, err1;

  spi_regfile_peripheral #(.CPOL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .spi(if0),
    .regs_flat(regs0), .wr_strobe(stb0), .frame_err(err0));
  spi_regfile_peripheral #(.CPOL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .spi(if1),
    .regs_flat(regs1), .wr_strobe(stb1), .frame_err(err1));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ncs_rise_cyc = 0;
  int stb_cnt [2];
  int err_cnt [2];
  int stb_cyc [2];
  logic [4:0] stb_last [2];
  int both_cnt = 0;
  int stray_cnt = 0;
  logic [7:0] mregs [2][5];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (stb0 != 5'd0) begin
      stb_cnt[0]  <= stb_cnt[0] + 1;
      stb_last[0] <= stb0;
      stb_cyc[0]  <= cyc;
    end
    if (stb1 != 5'd0) begin
      stb_cnt[1]  <= stb_cnt[1] + 1;
      stb_last[1] <= stb1;
      stb_cyc[1]  <= cyc;
    end
    if (err0) err_cnt[0] <= err_cnt[0] + 1;
    if (err1) err_cnt[1] <= err_cnt[1] + 1;
    if ((stb0 != 5'd0 && err0) || (stb1 != 5'd0 && err1)) both_cnt <= both_cnt + 1;
`ifndef SPI_READBACK_EN
    if (if0.CIPO || if0.cipo_oe || if1.CIPO || if1.cipo_oe) stray_cnt <= stray_cnt + 1;
`endif
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pins(input int w, input logic sclk, input logic copi, input logic ncs);
    if (w == 0) begin
      if0.SCLK = sclk; if0.COPI = copi; if0.nCS = ncs;
    end else begin
      if1.SCLK = sclk; if1.COPI = copi; if1.nCS = ncs;
    end
  endtask

  function automatic logic idle_lvl(input int w);
    return (w == 1);
  endfunction

  task automatic frame_begin(input int w);
    @(negedge clk);
    set_pins(w, idle_lvl(w), 1'b0, 1'b0);
    wait_clks(H);
  endtask

  // Data changes with the trailing edge; CIPO is sampled just before the leading edge.
  task automatic frame_bit(input int w, input logic b, output logic c, output logic oe);
    set_pins(w, idle_lvl(w), b, 1'b0);
    wait_clks(H);
    c  = (w == 0) ? if0.CIPO : if1.CIPO;
    oe = (w == 0) ? if0.cipo_oe : if1.cipo_oe;
    set_pins(w, ~idle_lvl(w), b, 1'b0);
    wait_clks(H);
  endtask

  task automatic frame_end(input int w);
    set_pins(w, idle_lvl(w), 1'b0, 1'b0);
    wait_clks(H);
    set_pins(w, idle_lvl(w), 1'b0, 1'b1);
    ncs_rise_cyc = cyc;
    wait_clks(12);
  endtask

  function automatic logic [39:0] model_flat(input int w);
    logic [39:0] f;
    for (int r = 0; r < 5; r++) f[r*8 +: 8] = mregs[w][r];
    return f;
  endfunction

  task automatic model_frame(input int w, input int nbits, input logic [31:0] word,
                             output logic [4:0] es, output int ee);
    int addr;
    es = 5'd0;
    ee = 0;
    addr = int'(word[14:8]);
    if (nbits == 16) begin
      if (word[15]) begin
        if (addr < 5) begin
          mregs[w][addr] = word[7:0];
          es[addr] = 1'b1;
        end else begin
          ee = 1;
        end
      end
    end else if (nbits != 0) begin
      ee = 1;
    end
  endtask

  task automatic run_txn(input int w, input int nbits, input logic [31:0] word,
                         input logic use_tab, input logic [4:0] tab_es, input int tab_ee);
    int s0, e0, ee, oel, addr;
    logic [4:0] es;
    logic [31:0] cb;
    logic c, oe;
    logic [7:0] exp_rd, act_rd;
    oel = 0;
    cb = '0;
    addr = int'(word[14:8]);
    exp_rd = (addr < 5) ? mregs[w][addr] : 8'h00;
    s0 = stb_cnt[w];
    e0 = err_cnt[w];
    frame_begin(w);
    for (int i = 0; i < nbits; i++) begin
      frame_bit(w, word[nbits-1-i], c, oe);
      if (i < 32) cb[i] = c;
      if (!oe) oel++;
    end
    frame_end(w);
    model_frame(w, nbits, word, es, ee);
    if (use_tab) begin
      es = tab_es;
      ee = tab_ee;
    end
    $display("txn dut=%0d bits=%0d word=%0h exp_strobe=%b exp_err=%0d regs0=%h regs1=%h",
             w, nbits, word, es, ee, regs0, regs1);
    check("regs_dut0", regs0, model_flat(0));
    check("regs_dut1", regs1, model_flat(1));
    check("strobe_pulses", stb_cnt[w] - s0, (es != 5'd0) ? 1 : 0);
    if (es != 5'd0) begin
      check("strobe_bit", stb_last[w], es);
      check("write_latency", stb_cyc[w] - ncs_rise_cyc, 4);
    end
    check("frame_err_pulses", err_cnt[w] - e0, ee);
`ifdef SPI_READBACK_EN
    if (nbits > 0) check("cipo_oe_in_frame_low", oel, 0);
    check("cipo_oe_idle", (w == 0) ? if0.cipo_oe : if1.cipo_oe, 1'b0);
    if (nbits == 16 && word[15] == 1'b0) begin
      for (int k = 0; k < 8; k++) act_rd[7-k] = cb[8+k];
      check("readback_data", act_rd, exp_rd);
    end
`endif
  endtask

  typedef struct {
    int         which;
    int         nbits;
    logic [31:0] word;
    logic [4:0] exp_strobe;
    int         exp_err;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int s0, e0, nb, rsel;
    logic [31:0] wd;
    logic c, oe;

    for (int d = 0; d < 2; d++) for (int r = 0; r < 5; r++) mregs[d][r] = 8'h00;
    set_pins(0, 1'b0, 1'b0, 1'b1);
    set_pins(1, 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    wait_clks(4);
    check("reset_regs0", regs0, 40'h0);
    check("reset_regs1", regs1, 40'h0);
    check("reset_strobe0", stb0, 5'd0);
    check("reset_strobe1", stb1, 5'd0);
    check("reset_err0", err0, 1'b0);
    check("reset_err1", err1, 1'b0);
    check("reset_cipo0", if0.CIPO, 1'b0);
    check("reset_oe0", if0.cipo_oe, 1'b0);
    check("reset_cipo1", if1.CIPO, 1'b0);
    check("reset_oe1", if1.cipo_oe, 1'b0);
    rst_n = 1'b1;
    wait_clks(10);

    vecs[0] = '{0, 16, 32'h84A5,  5'b10000, 0};
    vecs[1] = '{0, 16, 32'h8577,  5'b00000, 1};
    vecs[2] = '{0, 12, 32'h0813,  5'b00000, 1};
    vecs[3] = '{0, 17, 32'h10267, 5'b00000, 1};
    vecs[4] = '{1, 16, 32'h835A,  5'b01000, 0};
    vecs[5] = '{0, 0,  32'h0000,  5'b00000, 0};
    vecs[6] = '{0, 16, 32'h0400,  5'b00000, 0};
    vecs[7] = '{1, 16, 32'h803C,  5'b00001, 0};
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].which, vecs[i].nbits, vecs[i].word, 1'b1, vecs[i].exp_strobe, vecs[i].exp_err);
    end

`ifdef SPI_READBACK_EN
    run_txn(0, 16, 32'h823C, 1'b1, 5'b00100, 0);
    run_txn(0, 16, 32'h0200, 1'b1, 5'b00000, 0);
    run_txn(1, 16, 32'h0300, 1'b1, 5'b00000, 0);
    run_txn(0, 16, 32'h0600, 1'b1, 5'b00000, 0);
`endif

    // Reset in the middle of a write; the tail of that frame must be ignored.
    s0 = stb_cnt[0];
    e0 = err_cnt[0];
    wd = 32'h80FF;
    frame_begin(0);
    for (int i = 0; i < 10; i++) frame_bit(0, wd[15-i], c, oe);
    rst_n = 1'b0;
    wait_clks(3);
    for (int d = 0; d < 2; d++) for (int r = 0; r < 5; r++) mregs[d][r] = 8'h00;
    check("midreset_regs0", regs0, model_flat(0));
    check("midreset_regs1", regs1, model_flat(1));
    rst_n = 1'b1;
    for (int i = 10; i < 16; i++) frame_bit(0, wd[15-i], c, oe);
    frame_end(0);
    $display("txn dut=0 aborted-by-reset write word=80ff regs0=%h", regs0);
    check("aborted_regs0", regs0, model_flat(0));
    check("aborted_strobes", stb_cnt[0] - s0, 0);
    check("aborted_errs", err_cnt[0] - e0, 0);
    run_txn(0, 16, 32'h8001, 1'b1, 5'b00001, 0);

    for (int i = 0; i < 40; i++) begin
      rsel = $urandom_range(0, 9);
      if (rsel < 7) begin
        nb = 16;
        wd = (32'($urandom_range(0, 1)) << 15) | (32'($urandom_range(0, 6)) << 8) |
             32'($urandom_range(0, 255));
      end else begin
        nb = $urandom_range(0, 20);
        wd = $urandom;
      end
      run_txn($urandom_range(0, 1), nb, wd, 1'b0, 5'd0, 0);
    end

    check("strobe_err_same_cycle", both_cnt, 0);
`ifndef SPI_READBACK_EN
    check("cipo_tied_low", stray_cnt, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
